// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
`timescale 1ns/1ps
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a WIDTH-bit operation. Never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor: D = a - b - Bin, Bout is the borrow out.
`timescale 1ns/1ps
module full_sub (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin over WIDTH cycles, LSB first, through
// one full_sub cell with a registered borrow and a start/done handshake.
`timescale 1ns/1ps
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_brw;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bout;

  full_sub u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .Bin  (r_brw),
    .D    (w_d),
    .Bout (w_bout)
  );

  // Sequencer: load operands on start, shift one bit pair per cycle through
  // the cell, then pulse done for a single cycle before returning to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_brw   <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so after WIDTH shifts bit 0 is LSB.
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_brw  <= w_bout;
          r_bout <= w_bout;
          if (r_cnt == LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // Start is deliberately ignored here; the next op is taken in IDLE.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: 8-bit directed vectors plus an exhaustive
// 4-bit sweep against a reference subtraction.
`timescale 1ns/1ps
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       s8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       s4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation: returns result at the done pulse, done latency,
  // number of cycles busy was seen high, and number of done pulses.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     output logic [7:0] rd, output logic rb,
                     output int lat, output int bcnt, output int dcnt);
    a8 = ta; b8 = tb; bin8 = tbin; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    rd = 'x; rb = 1'bx; lat = -1; dcnt = 0;
    bcnt = busy8 ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy8) bcnt++;
      if (done8) begin
        dcnt++;
        if (lat < 0) begin lat = k; rd = diff8; rb = bout8; end
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                     output logic [3:0] rd, output logic rb,
                     output int lat, output int dcnt);
    a4 = ta; b4 = tb; bin4 = tbin; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    rd = 'x; rb = 1'bx; lat = -1; dcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        dcnt++;
        if (lat < 0) begin lat = k; rd = diff4; rb = bout4; end
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd8, d1, d2;
    logic [3:0] rd4;
    logic       rb, bo1, bo2, prevb;
    logic [4:0] ref5;
    int         lat, bcnt, dcnt, cyc, acc1, acc2, nd;

    // Reset held with start asserted: reset must win.
    rst_n = 1'b0; s8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
    s4 = 1'b1; a4 = 4'h7; b4 = 4'h2; bin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_diff8", diff8, 8'h00);
    chk("rst_bout8", bout8, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_diff4", diff4, 4'h0);
    s8 = 1'b0; s4 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic operation, latency and busy length.
    op8(8'h5A, 8'h3C, 1'b0, rd8, rb, lat, bcnt, dcnt);
    chk("5A-3C_diff", rd8, 8'h1E);
    chk("5A-3C_bout", rb, 1'b0);
    chk("5A-3C_latency", lat, 8);
    chk("5A-3C_busy_cycles", bcnt, 8);
    chk("5A-3C_done_pulses", dcnt, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_diff", diff8, 8'h1E);
    chk("idle_hold_bout", bout8, 1'b0);
    chk("idle_busy", busy8, 1'b0);

    // Underflow boundaries.
    op8(8'h00, 8'h01, 1'b0, rd8, rb, lat, bcnt, dcnt);
    chk("00-01_diff", rd8, 8'hFF);
    chk("00-01_bout", rb, 1'b1);
    op8(8'h80, 8'h80, 1'b1, rd8, rb, lat, bcnt, dcnt);
    chk("80-80-1_diff", rd8, 8'hFF);
    chk("80-80-1_bout", rb, 1'b1);
    chk("80-80-1_done_pulses", dcnt, 1);

    // Start held high: operand changes mid-shift are ignored and the second
    // acceptance lands WIDTH+2 cycles after the first.
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; s8 = 1'b1;
    cyc = 0; acc1 = -1; acc2 = -1; nd = 0; prevb = busy8;
    d1 = 'x; d2 = 'x; bo1 = 1'bx; bo2 = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (busy8 && !prevb) begin
        if (acc1 < 0) acc1 = cyc;
        else if (acc2 < 0) acc2 = cyc;
      end
      prevb = busy8;
      if (acc1 >= 0 && cyc == acc1 + 2) begin a8 = 8'h33; b8 = 8'h11; end
      if (done8) begin
        nd++;
        if (nd == 1) begin d1 = diff8; bo1 = bout8; end
        else begin d2 = diff8; bo2 = bout8; break; end
      end
    end
    s8 = 1'b0;
    chk("hold_start_first_diff", d1, 8'h0F);
    chk("hold_start_first_bout", bo1, 1'b0);
    chk("hold_start_spacing", acc2 - acc1, 10);
    chk("hold_start_done_count", nd, 2);
    chk("hold_start_second_diff", d2, 8'h22);
    chk("hold_start_second_bout", bo2, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during the 4th SHIFT cycle aborts the operation.
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_diff", diff8, 8'h00);
    chk("abort_bout", bout8, 1'b0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    chk("abort_no_done", nd, 0);
    op8(8'h03, 8'h05, 1'b0, rd8, rb, lat, bcnt, dcnt);
    chk("03-05_diff", rd8, 8'hFE);
    chk("03-05_bout", rb, 1'b1);

    // Two-word chain: 16'h1200 - 16'h00FF = 16'h1101.
    op8(8'h00, 8'hFF, 1'b0, rd8, rb, lat, bcnt, dcnt);
    chk("chain_lo_diff", rd8, 8'h01);
    chk("chain_lo_bout", rb, 1'b1);
    op8(8'h12, 8'h00, rb, rd8, rb, lat, bcnt, dcnt);
    chk("chain_hi_diff", rd8, 8'h11);
    chk("chain_hi_bout", rb, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ref5 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
          op4(4'(ia), 4'(ib), 1'(ic), rd4, rb, lat, dcnt);
          chk($sformatf("w4_%0h_%0h_%0d_diff", ia, ib, ic), rd4, ref5[3:0]);
          chk($sformatf("w4_%0h_%0h_%0d_bout", ia, ib, ic), rb, ref5[4]);
          chk($sformatf("w4_%0h_%0h_%0d_done", ia, ib, ic), dcnt, 1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
